// File: rtl/pe_arb_pkg.sv
// pe_arb_pkg: shared state encodings, source ids and helpers for the
// PE operand arbiter.
package pe_arb_pkg;

  // Arbiter lock states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  // Requester identifiers, also used directly as the mux select value
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Width of the optional per-requester grant counters
  localparam int STATS_W = 16;

  // The requester that is not src; used to hand priority over on release
  function automatic logic other_src(input logic src);
    return ~src;
  endfunction

  // Lock state that corresponds to a given requester
  function automatic state_t lock_state(input logic src);
    return (src == SRC_B) ? ST_LOCK_B : ST_LOCK_A;
  endfunction

endpackage

// File: rtl/pe_operand_arbiter_mux32.sv
// mux32: two-input word selector used as the operand datapath of the
// arbiter. switch=0 passes in0, switch=1 passes in1.
module mux32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             switch,
  output logic [WIDTH-1:0] dout
);

  // Pure combinational word select
  always_comb begin
    dout = switch ? in1 : in0;
  end

endmodule

// File: rtl/pe_operand_arbiter.sv
// pe_operand_arbiter: round-robin arbiter sharing one PE operand input
// between requesters A and B. A grant is locked for a burst until the
// source flags last, the burst reaches MAX_BURST beats, or the locked
// requester stalls for STALL_TIMEOUT cycles. The selected word is
// registered into a single full-throughput output stage.
// Optional build macro PE_ARB_STATS_EN adds saturating per-requester
// grant counters (a_grant_cnt, b_grant_cnt).
module pe_operand_arbiter
  import pe_arb_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MAX_BURST     = 8,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
`ifdef PE_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] a_grant_cnt,
  output logic [STATS_W-1:0] b_grant_cnt
`endif
);

  // Counter widths; a minimum of one bit keeps MAX_BURST=1 and
  // STALL_TIMEOUT=1 legal
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int SW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;

  localparam logic [BW-1:0] BEAT_LIMIT  = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(STALL_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            sel_q;

  logic            gnt_src;
  logic            gnt_any;
  logic            gnt_valid;
  logic            gnt_last;
  logic            load_en;
  logic            beat;
  logic            first_beat;
  logic [DATA_W-1:0] sel_data;

  // Grant decision: locked states own the grant outright; in IDLE the
  // winner is chosen in the same cycle, with the round-robin pointer
  // breaking ties and the previous select held when nobody asks
  always_comb begin
    gnt_src = sel_q;
    gnt_any = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_any = a_valid | b_valid;
        if (a_valid && b_valid) begin
          gnt_src = rr_ptr_q;
        end else if (a_valid) begin
          gnt_src = SRC_A;
        end else if (b_valid) begin
          gnt_src = SRC_B;
        end
      end
      ST_LOCK_A: begin
        gnt_any = 1'b1;
        gnt_src = SRC_A;
      end
      ST_LOCK_B: begin
        gnt_any = 1'b1;
        gnt_src = SRC_B;
      end
      default: begin
        gnt_any = 1'b0;
        gnt_src = sel_q;
      end
    endcase
  end

  // Handshake terms; readies are held low while reset is asserted so the
  // producers see nothing accepted during reset
  always_comb begin
    load_en    = !out_valid || out_ready;
    gnt_valid  = (gnt_src == SRC_B) ? b_valid : a_valid;
    gnt_last   = (gnt_src == SRC_B) ? b_last : a_last;
    a_ready    = rst_n && load_en && gnt_any && (gnt_src == SRC_A);
    b_ready    = rst_n && load_en && gnt_any && (gnt_src == SRC_B);
    beat       = rst_n && load_en && gnt_any && gnt_valid;
    first_beat = beat && (state_q == ST_IDLE);
    sel        = rst_n ? gnt_src : SRC_A;
    busy       = (state_q != ST_IDLE);
  end

  // Word selection through the shared datapath mux
  mux32 #(
    .WIDTH (DATA_W)
  ) u_mux (
    .in0    (a_data),
    .in1    (b_data),
    .switch (sel),
    .dout   (sel_data)
  );

  // Next-state logic: release on last/burst limit after a beat, extend the
  // lock on other beats, and count idle cycles toward a forced release
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    stall_d  = stall_q;
    if (beat) begin
      stall_d = '0;
      if (gnt_last || (beat_q == BEAT_LIMIT)) begin
        state_d  = ST_IDLE;
        rr_ptr_d = other_src(gnt_src);
        beat_d   = '0;
      end else begin
        state_d = lock_state(gnt_src);
        beat_d  = beat_q + BW'(1);
      end
    end else if (state_q != ST_IDLE) begin
      if (stall_q == STALL_LIMIT) begin
        state_d  = ST_IDLE;
        rr_ptr_d = other_src(gnt_src);
        beat_d   = '0;
        stall_d  = '0;
      end else begin
        stall_d = stall_q + SW'(1);
      end
    end
  end

  // Control state register, including the held mux select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= SRC_A;
      beat_q   <= '0;
      stall_q  <= '0;
      sel_q    <= SRC_A;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      stall_q  <= stall_d;
      sel_q    <= gnt_src;
    end
  end

  // Output stage: load on every beat, drop valid once the PE takes the
  // word, otherwise hold the word stable under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_A;
      out_last  <= 1'b0;
    end else if (beat) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= gnt_src;
      out_last  <= gnt_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PE_ARB_STATS_EN
  // Saturating grant counters, bumped on the opening beat of each grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else if (first_beat) begin
      if ((gnt_src == SRC_A) && (a_grant_cnt != '1)) begin
        a_grant_cnt <= a_grant_cnt + STATS_W'(1);
      end
      if ((gnt_src == SRC_B) && (b_grant_cnt != '1)) begin
        b_grant_cnt <= b_grant_cnt + STATS_W'(1);
      end
    end
  end
`else
  // Opening-beat flag only feeds the optional counters
  logic unused_first_beat;
  always_comb begin
    unused_first_beat = first_beat;
  end
`endif

endmodule
